// File: rtl/hemaia_mem_pkg.sv
// Shared definitions for the HeMAiA superbank memory slice: default widths,
// bank-count derivation and the grant type used by the superbank arbiter.
package hemaia_mem_pkg;

  localparam int unsigned NarrowDataWidthDef = 64;
  localparam int unsigned WideDataWidthDef   = 512;
  localparam int unsigned AddrWidthDef       = 10;
  localparam int unsigned MaxStarveDef       = 4;

  // Which side of the superbank owns the banks in the current cycle.
  typedef enum logic [1:0] {
    GrantNone   = 2'd0,
    GrantWide   = 2'd1,
    GrantNarrow = 2'd2
  } grant_e;

  // A wide beat spans exactly this many narrow banks.
  function automatic int unsigned calcNumBanks(input int unsigned wideWidth,
                                               input int unsigned narrowWidth);
    return wideWidth / narrowWidth;
  endfunction

endpackage

// File: rtl/hemaia_starve_cnt.sv
// Saturating starvation counter: counts consecutive cycles in which narrow
// traffic waited behind a wide grant and flags when the limit is reached.
module hemaia_starve_cnt #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned CntWidth = $clog2(Limit + 1);

  logic [CntWidth-1:0] r_cnt;

  // Clear has priority over increment; the count sticks at Limit until cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt < CntWidth'(Limit))) begin
      r_cnt <= r_cnt + CntWidth'(1);
    end
  end

  assign sat_o = (r_cnt == CntWidth'(Limit));

endmodule

// File: rtl/hemaia_superbank_arbiter.sv
// Superbank arbiter: shares one superbank of narrow SRAM banks between a
// wide port (all banks at once) and per-bank narrow ports, favouring the
// wide port but forcing a narrow grant after MaxStarve denied cycles.
module hemaia_superbank_arbiter
  import hemaia_mem_pkg::*;
#(
  parameter int unsigned NarrowDataWidth = NarrowDataWidthDef,
  parameter int unsigned WideDataWidth   = WideDataWidthDef,
  parameter int unsigned AddrWidth       = AddrWidthDef,
  parameter int unsigned MaxStarve       = MaxStarveDef,
  localparam int unsigned N              = calcNumBanks(WideDataWidth, NarrowDataWidth),
  localparam int unsigned StrbWidth      = NarrowDataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N-1:0]                   narrow_req_valid_i,
  output logic [N-1:0]                   narrow_req_ready_o,
  input  logic [N-1:0]                   narrow_req_write_i,
  input  logic [N*AddrWidth-1:0]         narrow_req_addr_i,
  input  logic [N*NarrowDataWidth-1:0]   narrow_req_data_i,
  input  logic [N*StrbWidth-1:0]         narrow_req_strb_i,
  output logic [N-1:0]                   narrow_rsp_valid_o,
  output logic [N*NarrowDataWidth-1:0]   narrow_rsp_data_o,
  input  logic                           wide_req_valid_i,
  output logic                           wide_req_ready_o,
  input  logic                           wide_req_write_i,
  input  logic [AddrWidth-1:0]           wide_req_addr_i,
  input  logic [WideDataWidth-1:0]       wide_req_data_i,
  input  logic [WideDataWidth/8-1:0]     wide_req_strb_i,
  output logic                           wide_rsp_valid_o,
  output logic [WideDataWidth-1:0]       wide_rsp_data_o,
  output logic [N-1:0]                   bank_cs_o,
  output logic [N-1:0]                   bank_we_o,
  output logic [N*AddrWidth-1:0]         bank_addr_o,
  output logic [N*StrbWidth-1:0]         bank_be_o,
  output logic [N*NarrowDataWidth-1:0]   bank_wdata_o,
  input  logic [N*NarrowDataWidth-1:0]   bank_rdata_i
);

  if ((MaxStarve < 1) || ((WideDataWidth % NarrowDataWidth) != 0)) begin : g_badParams
    $error("hemaia_superbank_arbiter: MaxStarve must be >= 1 and WideDataWidth a multiple of NarrowDataWidth");
  end

  grant_e         w_grant;
  logic           w_starved;
  logic           w_anyNarrow;
  logic           w_starveInc;
  logic           w_starveClr;
  logic           r_wideRspValid;
  logic [N-1:0]   r_narrowRspValid;

  assign w_anyNarrow = |narrow_req_valid_i;

  // Wide wins unless starvation has saturated; nobody is granted in reset.
  always_comb begin
    w_grant = GrantNone;
    if (!rst_i) begin
      if (wide_req_valid_i && !w_starved) begin
        w_grant = GrantWide;
      end else begin
        w_grant = GrantNarrow;
      end
    end
  end

  // Narrow traffic only starves when it is actually waiting behind wide.
  assign w_starveInc = (w_grant == GrantWide) && w_anyNarrow;
  assign w_starveClr = !w_starveInc;

  hemaia_starve_cnt #(
    .Limit (MaxStarve)
  ) u_starveCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_starveInc),
    .clr_i (w_starveClr),
    .sat_o (w_starved)
  );

  // Steer either the wide beat (sliced across banks) or each narrow port to its bank.
  always_comb begin
    wide_req_ready_o   = 1'b0;
    narrow_req_ready_o = '0;
    bank_cs_o          = '0;
    bank_we_o          = '0;
    bank_addr_o        = '0;
    bank_be_o          = '0;
    bank_wdata_o       = '0;
    case (w_grant)
      GrantWide: begin
        wide_req_ready_o = 1'b1;
        bank_cs_o        = '1;
        bank_we_o        = {N{wide_req_write_i}};
        bank_be_o        = wide_req_strb_i;
        bank_wdata_o     = wide_req_data_i;
        for (int j = 0; j < N; j++) begin
          bank_addr_o[j*AddrWidth +: AddrWidth] = wide_req_addr_i;
        end
      end
      GrantNarrow: begin
        narrow_req_ready_o = narrow_req_valid_i;
        bank_cs_o          = narrow_req_valid_i;
        for (int j = 0; j < N; j++) begin
          if (narrow_req_valid_i[j]) begin
            bank_we_o[j]                                      = narrow_req_write_i[j];
            bank_addr_o[j*AddrWidth +: AddrWidth]             = narrow_req_addr_i[j*AddrWidth +: AddrWidth];
            bank_be_o[j*StrbWidth +: StrbWidth]               = narrow_req_strb_i[j*StrbWidth +: StrbWidth];
            bank_wdata_o[j*NarrowDataWidth +: NarrowDataWidth] = narrow_req_data_i[j*NarrowDataWidth +: NarrowDataWidth];
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Reads answer one cycle later when SRAM data appears; writes never answer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wideRspValid   <= 1'b0;
      r_narrowRspValid <= '0;
    end else begin
      r_wideRspValid   <= (w_grant == GrantWide) && !wide_req_write_i;
      r_narrowRspValid <= (w_grant == GrantNarrow) ? (narrow_req_valid_i & ~narrow_req_write_i) : '0;
    end
  end

  assign wide_rsp_valid_o   = r_wideRspValid;
  assign narrow_rsp_valid_o = r_narrowRspValid;
  assign wide_rsp_data_o    = bank_rdata_i;
  assign narrow_rsp_data_o  = bank_rdata_i;

endmodule

// File: tb/tb_hemaia_superbank_arbiter.sv
// Self-checking bench for hemaia_superbank_arbiter: directed scenarios followed
// by randomized traffic, compared every cycle against a behavioural model.
module tb_hemaia_superbank_arbiter;

  localparam int NW = 64;
  localparam int WW = 512;
  localparam int AW = 10;
  localparam int MS = 4;
  localparam int N  = WW / NW;
  localparam int SW = NW / 8;

  logic              clk_i;
  logic              rst_i;
  logic [N-1:0]      narrow_req_valid_i;
  logic [N-1:0]      narrow_req_ready_o;
  logic [N-1:0]      narrow_req_write_i;
  logic [N*AW-1:0]   narrow_req_addr_i;
  logic [N*NW-1:0]   narrow_req_data_i;
  logic [N*SW-1:0]   narrow_req_strb_i;
  logic [N-1:0]      narrow_rsp_valid_o;
  logic [N*NW-1:0]   narrow_rsp_data_o;
  logic              wide_req_valid_i;
  logic              wide_req_ready_o;
  logic              wide_req_write_i;
  logic [AW-1:0]     wide_req_addr_i;
  logic [WW-1:0]     wide_req_data_i;
  logic [WW/8-1:0]   wide_req_strb_i;
  logic              wide_rsp_valid_o;
  logic [WW-1:0]     wide_rsp_data_o;
  logic [N-1:0]      bank_cs_o;
  logic [N-1:0]      bank_we_o;
  logic [N*AW-1:0]   bank_addr_o;
  logic [N*SW-1:0]   bank_be_o;
  logic [N*NW-1:0]   bank_wdata_o;
  logic [N*NW-1:0]   bank_rdata_i;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state: starvation count and reads awaiting their response.
  int           mStarve;
  logic         mWidePend;
  logic [N-1:0] mNarrowPend;

  hemaia_superbank_arbiter #(
    .NarrowDataWidth (NW),
    .WideDataWidth   (WW),
    .AddrWidth       (AW),
    .MaxStarve       (MS)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .narrow_req_valid_i (narrow_req_valid_i),
    .narrow_req_ready_o (narrow_req_ready_o),
    .narrow_req_write_i (narrow_req_write_i),
    .narrow_req_addr_i  (narrow_req_addr_i),
    .narrow_req_data_i  (narrow_req_data_i),
    .narrow_req_strb_i  (narrow_req_strb_i),
    .narrow_rsp_valid_o (narrow_rsp_valid_o),
    .narrow_rsp_data_o  (narrow_rsp_data_o),
    .wide_req_valid_i   (wide_req_valid_i),
    .wide_req_ready_o   (wide_req_ready_o),
    .wide_req_write_i   (wide_req_write_i),
    .wide_req_addr_i    (wide_req_addr_i),
    .wide_req_data_i    (wide_req_data_i),
    .wide_req_strb_i    (wide_req_strb_i),
    .wide_rsp_valid_o   (wide_rsp_valid_o),
    .wide_rsp_data_o    (wide_rsp_data_o),
    .bank_cs_o          (bank_cs_o),
    .bank_we_o          (bank_we_o),
    .bank_addr_o        (bank_addr_o),
    .bank_be_o          (bank_be_o),
    .bank_wdata_o       (bank_wdata_o),
    .bank_rdata_i       (bank_rdata_i)
  );

  // 10 ns clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    narrow_req_valid_i = '0;
    narrow_req_write_i = '0;
    narrow_req_addr_i  = '0;
    narrow_req_data_i  = '0;
    narrow_req_strb_i  = '0;
    wide_req_valid_i   = 1'b0;
    wide_req_write_i   = 1'b0;
    wide_req_addr_i    = '0;
    wide_req_data_i    = '0;
    wide_req_strb_i    = '0;
  endtask

  task automatic applyStimulus(input int wideProb);
    wide_req_valid_i   = ($urandom_range(99) < wideProb);
    wide_req_write_i   = $urandom_range(1);
    wide_req_addr_i    = AW'($urandom);
    wide_req_strb_i    = {$urandom, $urandom};
    for (int w = 0; w < WW / 32; w++) wide_req_data_i[w*32 +: 32] = $urandom;
    narrow_req_valid_i = N'($urandom & $urandom);
    narrow_req_write_i = N'($urandom);
    narrow_req_strb_i  = {$urandom, $urandom};
    for (int w = 0; w < N*NW / 32; w++) narrow_req_data_i[w*32 +: 32] = $urandom;
    for (int j = 0; j < N; j++) narrow_req_addr_i[j*AW +: AW] = AW'($urandom);
  endtask

  // Advance one clock; the model takes the same inputs the DUT sampled.
  task automatic cycle();
    logic wideG;
    @(posedge clk_i);
    wideG = wide_req_valid_i && (mStarve < MS);
    if (rst_i) begin
      mStarve     = 0;
      mWidePend   = 1'b0;
      mNarrowPend = '0;
    end else begin
      if (wideG && (narrow_req_valid_i != 0)) mStarve = (mStarve < MS) ? mStarve + 1 : MS;
      else                                    mStarve = 0;
      mWidePend   = wideG && !wide_req_write_i;
      mNarrowPend = wideG ? '0 : (narrow_req_valid_i & ~narrow_req_write_i);
    end
    #1;
    for (int w = 0; w < N*NW / 32; w++) bank_rdata_i[w*32 +: 32] = $urandom;
  endtask

  task automatic checkOutput();
    logic            expWide;
    logic [N-1:0]    expCs, expWe, obsWe;
    logic [N*AW-1:0] expAddr, obsAddr;
    logic [N*SW-1:0] expBe, obsBe;
    logic [N*NW-1:0] expWd, obsWd;
    #3;
    if (rst_i) begin
      chk("rst_wide_ready", wide_req_ready_o, 0);
      chk("rst_narrow_ready", narrow_req_ready_o, 0);
      chk("rst_cs", bank_cs_o, 0);
      return;
    end
    expWide = wide_req_valid_i && (mStarve < MS);
    expCs   = expWide ? '1 : narrow_req_valid_i;
    {expWe, obsWe, expAddr, obsAddr, expBe, obsBe, expWd, obsWd} = '0;
    for (int j = 0; j < N; j++) begin
      if (expCs[j]) begin
        obsWe[j]             = bank_we_o[j];
        obsAddr[j*AW +: AW]  = bank_addr_o[j*AW +: AW];
        obsBe[j*SW +: SW]    = bank_be_o[j*SW +: SW];
        obsWd[j*NW +: NW]    = bank_wdata_o[j*NW +: NW];
        expWe[j]             = expWide ? wide_req_write_i : narrow_req_write_i[j];
        expAddr[j*AW +: AW]  = expWide ? wide_req_addr_i : narrow_req_addr_i[j*AW +: AW];
        expBe[j*SW +: SW]    = expWide ? wide_req_strb_i[j*SW +: SW] : narrow_req_strb_i[j*SW +: SW];
        expWd[j*NW +: NW]    = expWide ? wide_req_data_i[j*NW +: NW] : narrow_req_data_i[j*NW +: NW];
      end
    end
    chk("wide_ready", wide_req_ready_o, expWide);
    chk("narrow_ready", narrow_req_ready_o, expWide ? '0 : narrow_req_valid_i);
    chk("bank_cs", bank_cs_o, expCs);
    chk("bank_we", obsWe, expWe);
    chk("bank_addr", obsAddr, expAddr);
    chk("bank_be", obsBe, expBe);
    chk("bank_wdata", obsWd, expWd);
    chk("wide_rsp_valid", wide_rsp_valid_o, mWidePend);
    if (mWidePend) chk("wide_rsp_data", wide_rsp_data_o, bank_rdata_i);
    chk("narrow_rsp_valid", narrow_rsp_valid_o, mNarrowPend);
    for (int j = 0; j < N; j++)
      if (mNarrowPend[j]) chk("narrow_rsp_data", narrow_rsp_data_o[j*NW +: NW], bank_rdata_i[j*NW +: NW]);
  endtask

  // Wide plus narrow bank 0 held valid: wide for MS cycles, then one narrow.
  task automatic runStarvePattern(input int cycles);
    idleInputs();
    wide_req_valid_i   = 1'b1;
    wide_req_addr_i    = 10'h011;
    narrow_req_valid_i = 8'h01;
    for (int k = 0; k < cycles; k++) begin
      checkOutput();
      chk("starve_pattern", wide_req_ready_o, (k % (MS + 1)) != MS);
      cycle();
    end
  endtask

  initial begin
    mStarve     = 0;
    mWidePend   = 1'b0;
    mNarrowPend = '0;
    bank_rdata_i = '0;
    rst_i = 1'b1;
    idleInputs();
    @(posedge clk_i);
    #1;

    // Reset holds every grant low even with requests pending
    applyStimulus(100);
    narrow_req_valid_i = '1;
    checkOutput();
    cycle();
    rst_i = 1'b0;
    idleInputs();
    checkOutput();
    cycle();

    // Wide read at 0x3A0
    wide_req_valid_i = 1'b1;
    wide_req_addr_i  = 10'h3A0;
    checkOutput();
    chk("wide_rd_cs", bank_cs_o, 8'hFF);
    chk("wide_rd_addr", bank_addr_o, {N{10'h3A0}});
    cycle();
    idleInputs();
    checkOutput();
    chk("wide_rd_rsp", wide_rsp_valid_o, 1'b1);
    chk("wide_rd_data", wide_rsp_data_o, bank_rdata_i);
    cycle();

    // Narrow writes on banks 2 and 5
    narrow_req_valid_i = 8'h24;
    narrow_req_write_i = 8'h24;
    narrow_req_addr_i  = {N{10'h155}};
    narrow_req_strb_i  = '1;
    checkOutput();
    chk("nwr_cs", bank_cs_o, 8'h24);
    chk("nwr_ready", narrow_req_ready_o, 8'h24);
    cycle();
    idleInputs();
    checkOutput();
    chk("nwr_no_rsp", narrow_rsp_valid_o, 0);
    cycle();

    // Starvation protection
    runStarvePattern(10);
    idleInputs();
    checkOutput();
    cycle();

    // Narrow read on bank 7 followed by reset: the response is dropped
    narrow_req_valid_i = 8'h80;
    checkOutput();
    cycle();
    idleInputs();
    rst_i = 1'b1;
    checkOutput();
    cycle();
    rst_i = 1'b0;
    checkOutput();
    chk("rst_drop_rsp", narrow_rsp_valid_o, 0);
    chk("rst_drop_wrsp", wide_rsp_valid_o, 0);
    runStarvePattern(5);
    idleInputs();
    checkOutput();
    cycle();

    // Wide write with low 32 strobe bytes cleared
    wide_req_valid_i = 1'b1;
    wide_req_write_i = 1'b1;
    wide_req_strb_i  = {32'hFFFF_FFFF, 32'h0000_0000};
    checkOutput();
    chk("wwr_be", bank_be_o, 64'hFFFF_FFFF_0000_0000);
    cycle();
    idleInputs();
    checkOutput();
    chk("wwr_no_rsp", wide_rsp_valid_o, 1'b0);
    cycle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus((i < 300) ? 85 : 50);
      rst_i = ($urandom_range(59) == 0);
      checkOutput();
      cycle();
    end
    rst_i = 1'b0;
    idleInputs();
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/hemaia_superbank_arbiter.md
HEMAIA_SUPERBANK_ARBITER -- requirements
Module: hemaia_superbank_arbiter

Sits downstream of the wide and narrow TCDM interconnects and upstream of one superbank of 64-bit SRAM banks. Arbitrates wide vs narrow access with starvation protection.

Interface
REQ-001 SHALL have parameter NarrowDataWidth, default 64, bank data width in bits.
REQ-002 SHALL have parameter WideDataWidth, default 512, wide port data width; N = WideDataWidth/NarrowDataWidth banks.
REQ-003 SHALL have parameter AddrWidth, default 10, bank word-address width.
REQ-004 SHALL have parameter MaxStarve, default 4, consecutive narrow-denied cycles before forced narrow grant.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 narrow_req_valid_i  in  N  per-bank narrow request valid.
REQ-008 narrow_req_ready_o  out  N  per-bank narrow grant.
REQ-009 narrow_req_write_i  in  N  per-bank write enable.
REQ-010 narrow_req_addr_i  in  N*AddrWidth  per-bank word address.
REQ-011 narrow_req_data_i  in  N*NarrowDataWidth  per-bank write data.
REQ-012 narrow_req_strb_i  in  N*NarrowDataWidth/8  per-bank byte strobes.
REQ-013 narrow_rsp_valid_o  out  N  per-bank read data valid.
REQ-014 narrow_rsp_data_o  out  N*NarrowDataWidth  per-bank read data.
REQ-015 wide_req_valid_i / wide_req_ready_o / wide_req_write_i  in/out/in  1 each  wide request handshake and write enable.
REQ-016 wide_req_addr_i  in  AddrWidth; wide_req_data_i  in  WideDataWidth; wide_req_strb_i  in  WideDataWidth/8.
REQ-017 wide_rsp_valid_o  out  1; wide_rsp_data_o  out  WideDataWidth  wide read response.
REQ-018 bank_cs_o, bank_we_o  out  N each; bank_addr_o  out  N*AddrWidth; bank_be_o  out  N*NarrowDataWidth/8; bank_wdata_o  out  N*NarrowDataWidth; bank_rdata_i  in  N*NarrowDataWidth (valid one cycle after cs).

Function
REQ-019 SHALL grant wide when wide_req_valid_i=1 and starve_cnt<MaxStarve; otherwise SHALL grant narrow.
REQ-020 Wide grant: wide_req_ready_o=1, all N narrow_req_ready_o=0, every bank_cs_o=1, addr=wide_req_addr_i, bank j gets wdata/strb slice j, bank_we_o=wide_req_write_i.
REQ-021 Narrow grant: wide_req_ready_o=0; bank j gets cs=ready=narrow_req_valid_i[j] with its own addr/data/strb/write; banks without valid get cs=0.
REQ-022 Ready/cs SHALL be combinational from current valids and registered starve_cnt (zero-cycle grant).
REQ-023 starve_cnt SHALL increment (saturating at MaxStarve) in cycles where any narrow valid is high and wide is granted; SHALL clear when narrow is granted with any narrow valid high or when no narrow valid is high.
REQ-024 At starve_cnt=MaxStarve with both sides valid: narrow granted, wide stalled (must hold valid), starve_cnt cleared next cycle.
REQ-025 Granted wide read: wide_rsp_valid_o=1 exactly one cycle later, wide_rsp_data_o = bank_rdata_i concatenated, bank 0 at LSBs.
REQ-026 Granted narrow read on bank j: narrow_rsp_valid_o[j]=1 exactly one cycle later, narrow_rsp_data_o slice j = bank_rdata_i slice j.
REQ-027 Writes SHALL produce no response valid.
REQ-028 Response valids SHALL be registered; response data passes combinationally from bank_rdata_i.
REQ-029 MaxStarve<1 or WideDataWidth not a multiple of NarrowDataWidth SHALL fail elaboration.

Reset
REQ-030 While rst_i=1: all ready and bank_cs_o outputs 0; starve_cnt, wide_rsp_valid_o, narrow_rsp_valid_o cleared at the edge.
REQ-031 Reset mid-operation SHALL drop in-flight responses: no response valid in the cycle after the reset edge.

Structure
REQ-032 N derivation and default widths SHALL live in shared package hemaia_mem_pkg.
REQ-033 Starvation counter SHALL be sub-module hemaia_starve_cnt (inc/clr inputs, saturating, limit parameter); remainder inline.

Verification
REQ-034 Wide read only, addr=0x3A0 -> all 8 cs=1, addr 0x3A0; next cycle wide_rsp_valid_o=1, data = concatenated bank_rdata.
REQ-035 Narrow writes on banks 2 and 5 only -> cs=0b00100100, ready same, no rsp valid next cycle.
REQ-036 Wide and narrow bank 0 valid continuously, MaxStarve=4 -> wide granted cycles 0-3, narrow cycle 4, wide cycle 5; pattern repeats every 5 cycles.
REQ-037 Narrow read bank 7 granted, rst_i=1 in following cycle -> narrow_rsp_valid_o stays 0; starve_cnt=0 after reset.
REQ-038 Wide write strb=0xFF..00 (low 32 bytes 0) -> bank_be_o 0x00 for banks 0-3, 0xFF for banks 4-7; wide_rsp_valid_o stays 0.
